// File: rtl/web0_wake_pkg.sv
`default_nettype none
// =============================================================================
// web0_wake_pkg : shared types and constants for the web0 wake-event logic
// Revision      : 1.0
// =============================================================================
package web0_wake_pkg;

   localparam int WEB_NUM_WAKE = 64;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'b00,
      ST_ENTER  = 2'b01,
      ST_SLEEP  = 2'b10,
      ST_EXIT   = 2'b11
   } web_state_e;

   // True when the transition prev->cur matches the selected edge type.
   function automatic logic edge_hit(input edge_sel_e sel, input logic cur, input logic prev);
      logic rise;
      logic fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      case (sel)
         EDGE_RISE: edge_hit = rise;
         EDGE_FALL: edge_hit = fall;
         EDGE_BOTH: edge_hit = rise | fall;
         default:   edge_hit = 1'b0;
      endcase
   endfunction

endpackage : web0_wake_pkg
`default_nettype wire

// File: rtl/web0_edge_det.sv
`default_nettype none
// =============================================================================
// web0_edge_det : synchroniser + previous-value flop + selectable edge detect
// Revision      : 1.0
// =============================================================================
module web0_edge_det
   import web0_wake_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit BYPASS_SYNC = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_async,
   input  logic [1:0] i_edge_sel,
   input  logic       i_armed,
   output logic       o_d,
   output logic       o_enb
);

   localparam int SYNC_DEPTH = BYPASS_SYNC ? 0 : SYNC_STAGES;

   logic w_cur;
   logic w_hit;
   logic r_prev;
   logic r_pulse;

   generate
      if (SYNC_DEPTH == 0) begin : g_bypass
         assign w_cur = i_async;
      end else begin : g_sync
         logic [SYNC_DEPTH-1:0] r_sync;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
            end
         end

         assign w_cur = r_sync[SYNC_DEPTH-1];
      end
   endgenerate

   assign w_hit = edge_hit(edge_sel_e'(i_edge_sel), w_cur, r_prev);

   // prev keeps tracking while disarmed so the first armed cycle sees no stale edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= w_cur;
         r_pulse <= w_hit & i_armed;
      end
   end

   // Hardware only ever sets event bits, so data and enable are the same pulse.
   assign o_d   = r_pulse;
   assign o_enb = r_pulse;

endmodule : web0_edge_det
`default_nettype wire

// File: rtl/web0_wake_event_detect.sv
`default_nettype none
// =============================================================================
// web0_wake_event_detect : wake/side-band edge detection into the web0 event
//                          register plus low-power entry/exit handshake FSM
// Revision               : 1.0
// =============================================================================
module web0_wake_event_detect
   import web0_wake_pkg::*;
#(
   parameter int NUM_WAKE    = WEB_NUM_WAKE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,

   input  logic [NUM_WAKE-1:0] wake_in,
   input  logic                low_pwr_in,
   input  logic                suppress_in,
   input  logic                epu_en_in,

   input  logic [1:0]          activate_low_pwr_edge_q,
   input  logic [1:0]          event_suppress_edge_q,
   input  logic [1:0]          wake_now_edge_q,
   input  logic [1:0]          epu_enable_edge_q,
   input  logic [NUM_WAKE-1:0] wake_enable_q,
   input  logic [NUM_WAKE-1:0] input_invert_q,

   input  logic                activate_low_pwr_q,
   input  logic                event_suppress_q,
   input  logic                wake_now_q,
   input  logic                epu_enable_q,

   output logic                activate_low_pwr_d,
   output logic                activate_low_pwr_enb,
   output logic                event_suppress_d,
   output logic                event_suppress_enb,
   output logic                wake_now_d,
   output logic                wake_now_enb,
   output logic                epu_enable_d,
   output logic                epu_enable_enb,

   output logic                lp_req,
   input  logic                lp_ack,
   output logic                wake_req,
   input  logic                wake_ack,
   output logic                wake_level,
   output logic [1:0]          fsm_state
);

   localparam int ARM_CYCLES = SYNC_STAGES + 1;
   localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

   // -------------------------------------------------------------------------
   // Post-reset arming window
   // -------------------------------------------------------------------------
   logic [ARM_W-1:0] r_arm_cnt;
   logic             w_armed;

   assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arm_cnt <= '0;
      end else if (!w_armed) begin
         r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Per-bit wake synchronisers, then invert/enable qualification
   // -------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][NUM_WAKE-1:0] r_wake_sync;
   logic [NUM_WAKE-1:0]                  w_qualified;
   logic                                 w_wake_src;
   logic                                 r_wake_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wake_sync <= '0;
      end else begin
         r_wake_sync[0] <= wake_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_wake_sync[s] <= r_wake_sync[s-1];
         end
      end
   end

   assign w_qualified = (r_wake_sync[SYNC_STAGES-1] ^ input_invert_q) & wake_enable_q;
   assign w_wake_src  = |w_qualified;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wake_level <= 1'b0;
      end else begin
         r_wake_level <= w_wake_src;
      end
   end

   assign wake_level = r_wake_level;

   // -------------------------------------------------------------------------
   // Edge detectors, one per event-register bit
   // -------------------------------------------------------------------------
   web0_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .BYPASS_SYNC (1'b0)
   ) u_activate_low_pwr (
      .clk        (clk),
      .rst        (rst),
      .i_async    (low_pwr_in),
      .i_edge_sel (activate_low_pwr_edge_q),
      .i_armed    (w_armed),
      .o_d        (activate_low_pwr_d),
      .o_enb      (activate_low_pwr_enb)
   );

   web0_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .BYPASS_SYNC (1'b0)
   ) u_event_suppress (
      .clk        (clk),
      .rst        (rst),
      .i_async    (suppress_in),
      .i_edge_sel (event_suppress_edge_q),
      .i_armed    (w_armed),
      .o_d        (event_suppress_d),
      .o_enb      (event_suppress_enb)
   );

   // Wake source is already synchronised bit-by-bit above.
   web0_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .BYPASS_SYNC (1'b1)
   ) u_wake_now (
      .clk        (clk),
      .rst        (rst),
      .i_async    (w_wake_src),
      .i_edge_sel (wake_now_edge_q),
      .i_armed    (w_armed),
      .o_d        (wake_now_d),
      .o_enb      (wake_now_enb)
   );

   web0_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .BYPASS_SYNC (1'b0)
   ) u_epu_enable (
      .clk        (clk),
      .rst        (rst),
      .i_async    (epu_en_in),
      .i_edge_sel (epu_enable_edge_q),
      .i_armed    (w_armed),
      .o_d        (epu_enable_d),
      .o_enb      (epu_enable_enb)
   );

   // -------------------------------------------------------------------------
   // Low-power entry/exit handshake FSM
   // -------------------------------------------------------------------------
   web_state_e r_state;
   web_state_e w_state_next;
   logic       r_lp_req;
   logic       r_wake_req;
   logic       w_lp_req_next;
   logic       w_wake_req_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_ACTIVE;
         r_lp_req   <= 1'b0;
         r_wake_req <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_lp_req   <= w_lp_req_next;
         r_wake_req <= w_wake_req_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ACTIVE: begin
            if (activate_low_pwr_q && epu_enable_q) begin
               w_state_next = ST_ENTER;
            end
         end
         // Once issued, the entry request stays up until acknowledged.
         ST_ENTER: begin
            if (lp_ack) begin
               w_state_next = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            if (wake_now_q && !event_suppress_q) begin
               w_state_next = ST_EXIT;
            end
         end
         ST_EXIT: begin
            if (wake_ack) begin
               w_state_next = ST_ACTIVE;
            end
         end
         default: w_state_next = ST_ACTIVE;
      endcase
      w_lp_req_next   = (w_state_next == ST_ENTER);
      w_wake_req_next = (w_state_next == ST_EXIT);
   end

   assign lp_req    = r_lp_req;
   assign wake_req  = r_wake_req;
   assign fsm_state = r_state;

endmodule : web0_wake_event_detect
`default_nettype wire

// File: tb/tb_web0_wake_event_detect.sv
`default_nettype none
// =============================================================================
// tb_web0_wake_event_detect : directed table-driven bench for the wake detector
// Revision                  : 1.0
// =============================================================================
module tb_web0_wake_event_detect;

   localparam int NW   = 64;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;

   localparam int SRC_WAKE = 0;
   localparam int SRC_EPU  = 1;
   localparam int SRC_LP   = 2;
   localparam int SRC_SUP  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NW-1:0] wake_in = '0;
   logic          low_pwr_in = 1'b0, suppress_in = 1'b0, epu_en_in = 1'b0;
   logic [1:0]    activate_low_pwr_edge_q = '0, event_suppress_edge_q = '0;
   logic [1:0]    wake_now_edge_q = '0, epu_enable_edge_q = '0;
   logic [NW-1:0] wake_enable_q = '0, input_invert_q = '0;
   logic          activate_low_pwr_q = 1'b0, event_suppress_q = 1'b0;
   logic          wake_now_q = 1'b0, epu_enable_q = 1'b0;
   logic          activate_low_pwr_d, activate_low_pwr_enb;
   logic          event_suppress_d, event_suppress_enb;
   logic          wake_now_d, wake_now_enb;
   logic          epu_enable_d, epu_enable_enb;
   logic          lp_req, wake_req, wake_level;
   logic          lp_ack = 1'b0, wake_ack = 1'b0;
   logic [1:0]    fsm_state;

   int n_tests = 0;
   int n_fail  = 0;

   web0_wake_event_detect #(
      .NUM_WAKE    (NW),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .wake_in                 (wake_in),
      .low_pwr_in              (low_pwr_in),
      .suppress_in             (suppress_in),
      .epu_en_in               (epu_en_in),
      .activate_low_pwr_edge_q (activate_low_pwr_edge_q),
      .event_suppress_edge_q   (event_suppress_edge_q),
      .wake_now_edge_q         (wake_now_edge_q),
      .epu_enable_edge_q       (epu_enable_edge_q),
      .wake_enable_q           (wake_enable_q),
      .input_invert_q          (input_invert_q),
      .activate_low_pwr_q      (activate_low_pwr_q),
      .event_suppress_q        (event_suppress_q),
      .wake_now_q              (wake_now_q),
      .epu_enable_q            (epu_enable_q),
      .activate_low_pwr_d      (activate_low_pwr_d),
      .activate_low_pwr_enb    (activate_low_pwr_enb),
      .event_suppress_d        (event_suppress_d),
      .event_suppress_enb      (event_suppress_enb),
      .wake_now_d              (wake_now_d),
      .wake_now_enb            (wake_now_enb),
      .epu_enable_d            (epu_enable_d),
      .epu_enable_enb          (epu_enable_enb),
      .lp_req                  (lp_req),
      .lp_ack                  (lp_ack),
      .wake_req                (wake_req),
      .wake_ack                (wake_ack),
      .wake_level              (wake_level),
      .fsm_state               (fsm_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         src;
      logic [1:0] sel;
      int         en_bit;
      int         chg_bit;
      logic       inv;
      logic       v0;
      logic       v1;
      int         exp_cnt;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_src(input int src, input int bitn, input logic v);
      case (src)
         SRC_WAKE: wake_in[bitn] = v;
         SRC_EPU:  epu_en_in     = v;
         SRC_LP:   low_pwr_in    = v;
         default:  suppress_in   = v;
      endcase
   endtask

   function automatic logic [1:0] get_pulse(input int src);
      case (src)
         SRC_WAKE: return {wake_now_d, wake_now_enb};
         SRC_EPU:  return {epu_enable_d, epu_enable_enb};
         SRC_LP:   return {activate_low_pwr_d, activate_low_pwr_enb};
         default:  return {event_suppress_d, event_suppress_enb};
      endcase
   endfunction

   function automatic logic any_enb();
      return activate_low_pwr_enb | event_suppress_enb | wake_now_enb | epu_enable_enb;
   endfunction

   task automatic goto_exit();
      activate_low_pwr_q = 1'b1; epu_enable_q = 1'b1;
      tick();
      activate_low_pwr_q = 1'b0; epu_enable_q = 1'b0;
      lp_ack = 1'b1;
      tick();
      lp_ack = 1'b0;
      wake_now_q = 1'b1; event_suppress_q = 1'b0;
      tick();
      wake_now_q = 1'b0;
   endtask

   initial begin
      int         cnt, first;
      logic       dbad, seen;
      logic [1:0] pd;

      //                src       sel    en  chg  inv   v0    v1  cnt
      vecs[0]  = '{SRC_WAKE, 2'b01, 37, 37, 1'b0, 1'b0, 1'b1, 1};
      vecs[1]  = '{SRC_WAKE, 2'b01, 37, 36, 1'b0, 1'b0, 1'b1, 0};
      vecs[2]  = '{SRC_WAKE, 2'b10, 37, 37, 1'b0, 1'b0, 1'b1, 0};
      vecs[3]  = '{SRC_WAKE, 2'b10, 37, 37, 1'b1, 1'b0, 1'b1, 1};
      vecs[4]  = '{SRC_WAKE, 2'b01,  0,  0, 1'b0, 1'b0, 1'b1, 1};
      vecs[5]  = '{SRC_WAKE, 2'b10, 63, 63, 1'b0, 1'b1, 1'b0, 1};
      vecs[6]  = '{SRC_EPU,  2'b10,  0,  0, 1'b0, 1'b1, 1'b0, 1};
      vecs[7]  = '{SRC_EPU,  2'b00,  0,  0, 1'b0, 1'b1, 1'b0, 0};
      vecs[8]  = '{SRC_EPU,  2'b01,  0,  0, 1'b0, 1'b1, 1'b0, 0};
      vecs[9]  = '{SRC_LP,   2'b01,  0,  0, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{SRC_SUP,  2'b11,  0,  0, 1'b0, 1'b1, 1'b0, 1};
      vecs[11] = '{SRC_SUP,  2'b11,  0,  0, 1'b0, 1'b0, 1'b1, 1};

      // ---- reset and idle with all-ones invert/enable ----
      input_invert_q = '1;
      wake_enable_q  = '1;
      activate_low_pwr_edge_q = 2'b11; event_suppress_edge_q = 2'b11;
      wake_now_edge_q = 2'b11;         epu_enable_edge_q = 2'b11;
      low_pwr_in = 1'b1;
      #2 rst = 1'b1;
      repeat (3) tick();
      check("reset_outputs",
            {activate_low_pwr_d, activate_low_pwr_enb, event_suppress_d, event_suppress_enb,
             wake_now_d, wake_now_enb, epu_enable_d, epu_enable_enb,
             lp_req, wake_req, wake_level, fsm_state}, 0);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         seen |= any_enb();
      end
      check("post_reset_no_enb", seen, 1'b0);
      check("idle_wake_level", wake_level, 1'b1);
      check("idle_fsm_active", fsm_state, 2'b00);

      // ---- table-driven edge vectors ----
      for (int i = 0; i < NV; i++) begin
         activate_low_pwr_edge_q = 2'b00; event_suppress_edge_q = 2'b00;
         wake_now_edge_q = 2'b00;         epu_enable_edge_q = 2'b00;
         wake_in = '0; input_invert_q = '0; wake_enable_q = '0;
         low_pwr_in = 1'b0; suppress_in = 1'b0; epu_en_in = 1'b0;
         case (vecs[i].src)
            SRC_WAKE: begin
               wake_now_edge_q = vecs[i].sel;
               wake_enable_q[vecs[i].en_bit]  = 1'b1;
               input_invert_q[vecs[i].en_bit] = vecs[i].inv;
            end
            SRC_EPU: epu_enable_edge_q       = vecs[i].sel;
            SRC_LP:  activate_low_pwr_edge_q = vecs[i].sel;
            default: event_suppress_edge_q   = vecs[i].sel;
         endcase
         set_src(vecs[i].src, vecs[i].chg_bit, vecs[i].v0);
         repeat (8) tick();
         set_src(vecs[i].src, vecs[i].chg_bit, vecs[i].v1);
         cnt = 0; first = -1; dbad = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            tick();
            pd = get_pulse(vecs[i].src);
            if (pd[0]) begin
               cnt++;
               if (first < 0) first = c;
            end
            if (pd[1] !== pd[0]) dbad = 1'b1;
         end
         check($sformatf("vec%0d_pulse_count", i), cnt, vecs[i].exp_cnt);
         if (vecs[i].exp_cnt > 0) begin
            check($sformatf("vec%0d_latency", i), first, LAT);
         end
         check($sformatf("vec%0d_d_eq_enb", i), dbad, 1'b0);
      end

      // ---- both-edge select with edges 8 cycles apart ----
      epu_enable_edge_q = 2'b11; epu_en_in = 1'b0;
      repeat (8) tick();
      cnt = 0;
      epu_en_in = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (epu_enable_enb) cnt++;
      end
      epu_en_in = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (epu_enable_enb) cnt++;
      end
      check("both_edges_two_pulses", cnt, 2);
      epu_enable_edge_q = 2'b00;

      // ---- simultaneous edges on two sources ----
      activate_low_pwr_edge_q = 2'b01; event_suppress_edge_q = 2'b01;
      low_pwr_in = 1'b0; suppress_in = 1'b0;
      repeat (8) tick();
      low_pwr_in = 1'b1; suppress_in = 1'b1;
      repeat (LAT) tick();
      check("simultaneous_enb", {activate_low_pwr_enb, event_suppress_enb}, 2'b11);
      tick();
      check("simultaneous_enb_one_cycle", {activate_low_pwr_enb, event_suppress_enb}, 2'b00);
      activate_low_pwr_edge_q = 2'b00; event_suppress_edge_q = 2'b00;

      // ---- FSM: entry handshake ----
      activate_low_pwr_q = 1'b1; epu_enable_q = 1'b1;
      check("lp_req_not_before_edge", lp_req, 1'b0);
      tick();
      check("enter_lp_req", {fsm_state, lp_req}, {2'b01, 1'b1});
      activate_low_pwr_q = 1'b0; epu_enable_q = 1'b0;
      seen = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         seen &= lp_req & (fsm_state == 2'b01);
      end
      check("lp_req_held_without_ack", seen, 1'b1);
      lp_ack = 1'b1;
      tick();
      lp_ack = 1'b0;
      check("sleep_after_ack", {fsm_state, lp_req}, {2'b10, 1'b0});

      // ---- FSM: suppressed wake, then exit ----
      wake_now_q = 1'b1; event_suppress_q = 1'b1;
      repeat (3) tick();
      check("suppress_holds_sleep", {fsm_state, wake_req}, {2'b10, 1'b0});
      event_suppress_q = 1'b0;
      tick();
      check("exit_wake_req", {fsm_state, wake_req}, {2'b11, 1'b1});
      wake_now_q = 1'b0;
      repeat (2) tick();
      check("wake_req_held", {fsm_state, wake_req}, {2'b11, 1'b1});
      wake_ack = 1'b1;
      tick();
      wake_ack = 1'b0;
      check("active_after_wake_ack", {fsm_state, wake_req}, {2'b00, 1'b0});

      // ---- FSM: lp_ack and wake condition together in ENTER ----
      activate_low_pwr_q = 1'b1; epu_enable_q = 1'b1;
      tick();
      activate_low_pwr_q = 1'b0; epu_enable_q = 1'b0;
      lp_ack = 1'b1; wake_now_q = 1'b1; event_suppress_q = 1'b0;
      tick();
      lp_ack = 1'b0;
      check("enter_ack_wake_goes_sleep", fsm_state, 2'b10);
      tick();
      wake_now_q = 1'b0;
      check("then_exit", {fsm_state, wake_req}, {2'b11, 1'b1});
      wake_ack = 1'b1;
      tick();
      wake_ack = 1'b0;

      // ---- asynchronous reset while in EXIT ----
      goto_exit();
      check("pre_reset_exit", {fsm_state, wake_req}, {2'b11, 1'b1});
      rst = 1'b1;
      #2;
      check("async_reset_exit", {fsm_state, wake_req}, {2'b00, 1'b0});
      tick();
      rst = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_web0_wake_event_detect
`default_nettype wire
